// File: rtl/ims1420_ctrl.sv
// rtl/ims1420_ctrl.sv - sequencer for an IMS1420-style 4K x 4 SRAM with bulk fill
module ims1420_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              wr_done,
    input  logic              init_start,
    input  logic [DATA_W-1:0] init_value,
    output logic              init_busy,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              sram_we_b,
    output logic              sram_e_b
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] wait_cnt;
    logic       op_write;

    // Fill requests take priority, so a pending init_start masks the request channel.
    assign req_ready = (state == S_IDLE) && !rsp_valid && !init_start;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            op_write  <= 1'b0;
            sram_e_b  <= 1'b1;
            sram_we_b <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            wr_done   <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            wr_done   <= 1'b0;
            init_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (init_start) begin
                        init_busy <= 1'b1;
                        op_write  <= 1'b1;
                        sram_addr <= '0;
                        sram_din  <= init_value;
                        state     <= S_SETUP;
                    end else if (req_valid && req_ready) begin
                        op_write  <= req_we;
                        sram_addr <= req_addr;
                        sram_din  <= req_wdata;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    sram_e_b  <= 1'b0;
                    sram_we_b <= !op_write;
                    wait_cnt  <= 4'd0;
                    state     <= S_STROBE;
                end
                S_STROBE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        sram_e_b  <= 1'b1;
                        sram_we_b <= 1'b1;
                        if (!op_write) begin
                            rsp_data <= sram_dout;
                        end
                        state <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (init_busy) begin
                        // Stop after the top address so the counter never wraps back to 0.
                        if (&sram_addr) begin
                            init_busy <= 1'b0;
                            init_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            sram_addr <= sram_addr + ADDR_ONE;
                            state     <= S_SETUP;
                        end
                    end else begin
                        if (op_write) begin
                            wr_done <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
